// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the entry type carried through the prefetch FIFO.
package fetch_pkg;
    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WIDTH-1:0] pc_plus4(input logic [WIDTH-1:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Power-of-two FIFO of fetch entries with synchronous clear and occupancy count.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1'b1);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             full_s;

    // A push into a full FIFO is only legal when a pop frees the slot in the same cycle
    always_comb begin
        full_s    = (count_r == FULL_C);
        do_pop_s  = pop && (count_r != ZERO_C);
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_C;
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == ZERO_C);
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch with prefetch FIFO: issues sequential requests, tags in-order
// responses with their PC, and squashes responses belonging to a redirected stream.
module fetch_queue #(
    parameter int                WIDTH    = fetch_pkg::WIDTH,
    parameter int                DEPTH    = 4,
    parameter logic [WIDTH-1:0]  RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrcE,
    input  logic [WIDTH-1:0] PCTargetE,
    input  logic             StallD,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic             ValidD,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D
);
    import fetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1'b1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [WIDTH-1:0] pc_f_r;
    logic [WIDTH-1:0] rsp_pc_r;
    logic [CNT_W-1:0] inflight_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0] fifo_count_s;
    logic [CNT_W:0]   occupancy_s;
    logic             req_valid_s;
    logic             accept_s;
    logic             squash_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_empty_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_entry_s;
    logic             valid_d_r;
    logic [WIDTH-1:0] instr_d_r;
    logic [WIDTH-1:0] pc_d_r;
    logic [WIDTH-1:0] pc_plus4_d_r;

    // Outstanding requests plus buffered entries never exceed FIFO capacity, so kept responses always fit
    always_comb begin
        occupancy_s        = {1'b0, inflight_r} + {1'b0, fifo_count_s};
        req_valid_s        = !PCSrcE && (occupancy_s < DEPTH_C);
        accept_s           = req_valid_s && imem_req_ready;
        squash_s           = PCSrcE || (drop_cnt_r != ZERO_C);
        push_s             = imem_rsp_valid && !squash_s;
        pop_s              = !PCSrcE && !StallD && !fifo_empty_s;
        push_entry_s.pc    = rsp_pc_r;
        push_entry_s.instr = imem_rsp_data;
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (PCSrcE),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_entry_s),
        .rdata (head_entry_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    // Request PC, response PC tag, outstanding and squash counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f_r     <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            inflight_r <= ZERO_C;
            drop_cnt_r <= ZERO_C;
        end else begin
            case ({accept_s, imem_rsp_valid})
                2'b10:   inflight_r <= inflight_r + ONE_C;
                2'b01:   inflight_r <= inflight_r - ONE_C;
                default: inflight_r <= inflight_r;
            endcase
            if (PCSrcE) begin
                pc_f_r   <= PCTargetE;
                rsp_pc_r <= PCTargetE;
                // Everything still outstanding after this edge belongs to the old stream
                drop_cnt_r <= imem_rsp_valid ? (inflight_r - ONE_C) : inflight_r;
            end else begin
                if (accept_s) begin
                    pc_f_r <= pc_plus4(pc_f_r);
                end
                if (push_s) begin
                    rsp_pc_r <= pc_plus4(rsp_pc_r);
                end
                if (imem_rsp_valid && (drop_cnt_r != ZERO_C)) begin
                    drop_cnt_r <= drop_cnt_r - ONE_C;
                end
            end
        end
    end

    // IF/ID pipeline register; redirect wins over stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_d_r    <= 1'b0;
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= {WIDTH{1'b0}};
            pc_plus4_d_r <= {WIDTH{1'b0}};
        end else if (PCSrcE) begin
            valid_d_r <= 1'b0;
        end else if (!StallD) begin
            if (fifo_empty_s) begin
                valid_d_r <= 1'b0;
                instr_d_r <= NOP_INSTR;
            end else begin
                valid_d_r    <= 1'b1;
                instr_d_r    <= head_entry_s.instr;
                pc_d_r       <= head_entry_s.pc;
                pc_plus4_d_r <= pc_plus4(head_entry_s.pc);
            end
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_f_r;
    assign ValidD         = valid_d_r;
    assign InstrD         = instr_d_r;
    assign PCD            = pc_d_r;
    assign PCPlus4D       = pc_plus4_d_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues the expected PC stream,
// a monitor compares each new IF/ID beat; memory model returns mem[a] = a | 0x13.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        StallD = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    int cyc    = 0;
    int lat    = 1;
    int max_out = 0;
    bit rdy_rand = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic        load_cap = 1'b0;

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 3000; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int target;
        target = beats + n;
        for (int i = 0; i < budget && beats < target; i++) step();
        checks++;
        if (beats < target) begin
            errors++;
            $display("FAIL beat_timeout actual=%0d required=%0d", beats, target);
        end
    endtask

    // Memory model: in-order, fixed latency, optional random ready
    initial begin : memory
        logic        acc;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            acc = imem_req_valid && imem_req_ready && rst;
            a   = imem_addr;
            @(posedge clk);
            cyc++;
            if (!rst) begin
                mq_addr.delete();
                mq_due.delete();
            end else if (acc) begin
                mq_addr.push_back(a);
                mq_due.push_back(cyc + lat - 1);
            end
            if (mq_addr.size() > max_out) max_out = mq_addr.size();
            #1;
            if (rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mq_addr.pop_front() | 32'h13;
                void'(mq_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // A new IF/ID beat exists after an edge that loaded the register
    always @(posedge clk) load_cap <= rst && !PCSrcE && !StallD;

    always @(negedge clk) begin
        logic [31:0] e;
        if (load_cap && ValidD) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=%h required=none", PCD);
            end else begin
                e = exp_q.pop_front();
                check("PCD", PCD, e);
                check("InstrD", InstrD, e | 32'h13);
                check("PCPlus4D", PCPlus4D, e + 32'd4);
                beats++;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] held_pc;
        // Reset state
        step(); step(); step();
        check("rst_ValidD", {31'b0, ValidD}, 32'h0);
        check("rst_InstrD", InstrD, 32'h0000_0013);
        check("rst_PCD", PCD, 32'h0);
        check("rst_PCPlus4D", PCPlus4D, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        restart_stream(32'h0);
        rst = 1'b1;
        // First beat appears after the third edge following release
        @(negedge clk);
        step(); @(negedge clk); check("lat_edge1", {31'b0, ValidD}, 32'h0);
        step(); @(negedge clk); check("lat_edge2", {31'b0, ValidD}, 32'h0);
        step(); @(negedge clk); check("lat_edge3", {31'b0, ValidD}, 32'h1);
        check("lat_pc", PCD, 32'h0);
        wait_beats(20, 60);

        // Stall six cycles: IF/ID holds, FIFO fills, requests stop
        step();
        StallD = 1'b1;
        step(); @(negedge clk);
        held_pc = PCD;
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        check("stall_hold_pc", PCD, held_pc);
        check("stall_valid", {31'b0, ValidD}, 32'h1);
        check("stall_req_low", {31'b0, imem_req_valid}, 32'h0);
        step();
        StallD = 1'b0;
        wait_beats(10, 40);

        // Redirect near the top of the address space to exercise PC wrap
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFF8;
        step();
        PCSrcE = 1'b0;
        restart_stream(32'hFFFF_FFF8);
        @(negedge clk);
        check("redir_valid_low", {31'b0, ValidD}, 32'h0);
        wait_beats(10, 40);

        // Redirect with stall in the same cycle as a returning response
        StallD = 1'b1;
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0200;
        step();
        PCSrcE = 1'b0;
        restart_stream(32'h0000_0200);
        @(negedge clk);
        check("redir_stall_v1", {31'b0, ValidD}, 32'h0);
        step(); @(negedge clk);
        check("redir_stall_v2", {31'b0, ValidD}, 32'h0);
        StallD = 1'b0;
        wait_beats(10, 40);

        // Three-cycle memory: redirect with requests in flight, then random ready
        lat = 3;
        wait_beats(8, 60);
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0100;
        step();
        PCSrcE = 1'b0;
        restart_stream(32'h0000_0100);
        rdy_rand = 1'b1;
        wait_beats(1000, 20000);

        // Reset mid-transaction with FIFO filling under stall
        rdy_rand = 1'b0;
        StallD = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        #1;
        check("mid_rst_ValidD", {31'b0, ValidD}, 32'h0);
        check("mid_rst_InstrD", InstrD, 32'h0000_0013);
        check("mid_rst_PCD", PCD, 32'h0);
        check("mid_rst_PCPlus4D", PCPlus4D, 32'h0);
        check("mid_rst_addr", imem_addr, 32'h0);
        restart_stream(32'h0);
        step(); step(); step();
        lat = 1;
        StallD = 1'b0;
        rst = 1'b1;
        wait_beats(20, 80);

        checks++;
        if (max_out > 4) begin
            errors++;
            $display("FAIL max_outstanding actual=%0d required<=4", max_out);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath width; DEPTH, 4, prefetch FIFO entries (power of two, >=2); RESET_PC, 32'h0, first fetch address.
REQ-002 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 PCSrcE  in  1  redirect from execute (taken branch/jump).
REQ-005 PCTargetE  in  WIDTH  redirect target.
REQ-006 StallD  in  1  decode holds IF/ID register.
REQ-007 imem_req_valid  out  1 / imem_req_ready  in  1 / imem_addr  out  WIDTH  instruction-memory request channel.
REQ-008 imem_rsp_valid  in  1 / imem_rsp_data  in  WIDTH  in-order response, no backpressure.
REQ-009 ValidD  out  1 / InstrD  out  WIDTH / PCD  out  WIDTH / PCPlus4D  out  WIDTH  registered IF/ID outputs to decode.

Function
REQ-010 PCF register SHALL drive imem_addr; request accepted when imem_req_valid && imem_req_ready, then PCF <= PCF+4 (mod 2^WIDTH, wrap silent).
REQ-011 imem_req_valid SHALL be combinational: !PCSrcE && (inflight + fifo_count < DEPTH).
REQ-012 inflight SHALL count accepted-but-unanswered requests (incl. doomed ones); +1 on accept, -1 on rsp_valid, both same cycle = unchanged.
REQ-013 rsp_pc register SHALL hold PC of next expected kept response; +4 per kept response.
REQ-014 Kept response (drop_cnt==0) SHALL push {rsp_pc, imem_rsp_data} into FIFO; FIFO never overflows by REQ-011.
REQ-015 drop_cnt>0: response SHALL be discarded, drop_cnt-1, no push.
REQ-016 IF/ID: if PCSrcE -> ValidD<=0; else if !StallD -> ValidD<=!fifo_empty, load head into InstrD/PCD, PCPlus4D<=head PC+4, pop if non-empty; else hold all.
REQ-017 When ValidD<=0 due to empty FIFO, InstrD SHALL load NOP 32'h00000013, PCD/PCPlus4D hold.
REQ-018 No FIFO bypass: response sampled at edge N reaches IF/ID at earliest edge N+1; with 1-cycle memory, request accepted at edge N gives ValidD high after edge N+2.
REQ-019 Redirect (PCSrcE=1) SHALL in one edge: PCF<=PCTargetE, rsp_pc<=PCTargetE, FIFO cleared, drop_cnt<=inflight_next - (pending kept beyond) i.e. drop_cnt<=drop_cnt+inflight_kept minus any response arriving this cycle; ValidD<=0.
REQ-020 Response arriving in the redirect cycle SHALL be discarded and SHALL decrement inflight.
REQ-021 Redirect SHALL override StallD; back-to-back redirects SHALL accumulate drop_cnt correctly.
REQ-022 Push and pop in the same cycle SHALL leave fifo_count unchanged, including at full and empty.

Reset
REQ-023 rst low SHALL immediately force: PCF=RESET_PC, rsp_pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0, ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0.
REQ-024 Reset mid-transaction SHALL abandon all in-flight requests; memory is reset concurrently, no late responses expected.
REQ-025 First request SHALL issue in the first cycle after rst deasserts.

Structure
REQ-026 Package fetch_pkg SHALL hold WIDTH, NOP_INSTR, RESET_PC default and the fetch entry struct {pc, instr}.
REQ-027 One sub-module sync_fifo (DEPTH entries, push/pop/clear, count) SHALL store fetch entries; counters sized $clog2(DEPTH)+1.

Verification
REQ-028 Reset release, 1-cycle memory returning mem[a]=a|0x13: ValidD high from third edge, PCD=0,4,8,... consecutive, InstrD matches.
REQ-029 StallD held 6 cycles: FIFO fills to 4, imem_req_valid low, IF/ID holds PCD constant; release -> sequence resumes without gap or duplicate.
REQ-030 Two requests in flight (PC 8,12), PCSrcE with PCTargetE=0x100: both responses discarded, next ValidD shows PCD=0x100.
REQ-031 Response arrives in same cycle as PCSrcE plus StallD=1: response dropped, ValidD=0 next cycle, no stale PC ever presented.
REQ-032 imem_req_ready toggling randomly, 3-cycle response latency, 1000 instructions: PCD strictly +4 per ValidD beat, inflight+fifo_count never exceeds 4.
REQ-033 rst asserted with 3 in flight and full FIFO: all outputs at reset values immediately; after release fetch restarts at RESET_PC.
